// File: rtl/hamming_pkg.sv
// Shared constants, FSM states and codeword helpers for the Hamming frame sequencer.
package hamming_pkg;

  localparam int BLOCKS  = 8;
  localparam int CW_W    = 16;
  localparam int BYTE_W  = 8;
  localparam int SYN_W   = 4;
  localparam int FRAME_W = BLOCKS * CW_W;
  localparam int DATA_W  = BLOCKS * BYTE_W;
  localparam int SYNS_W  = BLOCKS * SYN_W;

  typedef enum logic [1:0] {
    FILL,
    DECODE,
    OUT
  } state_t;

  // Only bits 14..3 of a codeword take part in the parity checks, so only they are passed in.
  // The result is the 1-based Hamming position of a single flipped bit, where position p
  // lives at codeword bit 15-p.
  function automatic logic [SYN_W-1:0] syndrome(input logic [CW_W-2:3] cw);
    logic p0;
    logic p1;
    logic p2;
    logic p3;
    p0 = cw[14] ^ cw[12] ^ cw[10] ^ cw[8] ^ cw[6] ^ cw[4];
    p1 = cw[13] ^ cw[12] ^ cw[9]  ^ cw[8] ^ cw[5] ^ cw[4];
    p2 = cw[11] ^ cw[10] ^ cw[9]  ^ cw[8] ^ cw[3];
    p3 = cw[7]  ^ cw[6]  ^ cw[5]  ^ cw[4] ^ cw[3];
    return {p3, p2, p1, p0};
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Positions that carry data bits; any other nonzero syndrome leaves the byte untouched.
  function automatic logic isDataPos(input logic [SYN_W-1:0] pos);
    case (pos)
      4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hamming_decoder.sv
// Combinational 8-block Hamming decoder: corrects a single data-bit error per block and
// extracts the 8 data bits of each 16-bit codeword (byte MSB = codeword bit 12).
module hamming_decoder
  import hamming_pkg::*;
(
  input  logic [FRAME_W-1:0] data_in,
  output logic [DATA_W-1:0]  data_out,
  output logic [SYNS_W-1:0]  error_positions
);

  logic [CW_W-1:0]  cw;
  logic [CW_W-1:0]  fixed;
  logic [SYN_W-1:0] syn;
  logic             unusedBits;

  // Per block: locate the flipped bit, correct it when it is a data bit, then pick out the byte.
  always_comb begin
    data_out        = '0;
    error_positions = '0;
    cw              = '0;
    fixed           = '0;
    syn             = '0;
    unusedBits      = 1'b0;
    for (int i = 0; i < BLOCKS; i++) begin
      cw    = data_in[CW_W*i +: CW_W];
      syn   = syndrome(cw[CW_W-2:3]);
      fixed = cw;
      if (isDataPos(syn)) begin
        fixed[4'd15 - syn] = ~fixed[4'd15 - syn];
      end
      data_out[BYTE_W*i +: BYTE_W] = {fixed[12], fixed[10], fixed[9], fixed[8],
                                      fixed[6],  fixed[5],  fixed[4], fixed[3]};
      error_positions[SYN_W*i +: SYN_W] = syn;
      unusedBits = unusedBits ^ fixed[15] ^ fixed[14] ^ fixed[13] ^ fixed[11] ^ fixed[7]
                   ^ (^fixed[2:0]);
    end
  end

endmodule

// File: rtl/hamming_frame_sequencer.sv
// Streaming front-end: gathers eight codewords into a frame, decodes it, holds the result
// on a valid/ready output and keeps saturating frame / corrected-block statistics.
module hamming_frame_sequencer
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CW_W-1:0]    in_word,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [BLOCKS-1:0]  out_err_mask,
  output logic [SYNS_W-1:0]  out_syndromes,
  output logic [CNT_W-1:0]   frame_count,
  output logic [CNT_W-1:0]   corr_count
);

  state_t              state_q;
  logic [2:0]          idx_q;
  logic [FRAME_W-1:0]  frame_q;
  logic                inReady_q;
  logic                outValid_q;
  logic [DATA_W-1:0]   outData_q;
  logic [BLOCKS-1:0]   errMask_q;
  logic [SYNS_W-1:0]   syndromes_q;
  logic [CNT_W-1:0]    frameCnt_q;
  logic [CNT_W-1:0]    corrCnt_q;

  logic                accept;
  logic                doFlush;
  logic                goDecode;
  logic [3:0]          padFrom;
  logic [FRAME_W-1:0]  frame_d;
  logic [SYNS_W-1:0]   syndromes;
  logic [BLOCKS-1:0]   errMask;
  logic [DATA_W-1:0]   decData;
  logic [CNT_W-1:0]    frameCnt_d;
  logic [CNT_W-1:0]    corrCnt_d;
  logic [CNT_W:0]      corrSum;

  hamming_decoder u_decoder (
    .data_in         (frame_q),
    .data_out        (decData),
    .error_positions ()
  );

  // Next frame contents: store an accepted word, and on flush zero every slot after the last
  // word taken this cycle (an accept in the flush cycle lands before the padding starts).
  always_comb begin
    accept  = in_valid & inReady_q;
    frame_d = frame_q;
    if (accept) begin
      frame_d[CW_W*int'(idx_q) +: CW_W] = in_word;
    end
    padFrom = {1'b0, idx_q} + {3'b000, accept};
    doFlush = flush && (state_q == FILL) && (accept || (idx_q != 3'd0));
    if (doFlush) begin
      for (int i = 0; i < BLOCKS; i++) begin
        if (4'(i) >= padFrom) begin
          frame_d[CW_W*i +: CW_W] = '0;
        end
      end
    end
    goDecode = (accept && (idx_q == 3'd7)) || doFlush;
  end

  // Syndromes and error mask are taken straight from the held frame so they are ready in DECODE.
  always_comb begin
    syndromes = '0;
    errMask   = '0;
    for (int i = 0; i < BLOCKS; i++) begin
      syndromes[SYN_W*i +: SYN_W] = syndrome(frame_q[CW_W*i+3 +: CW_W-4]);
      errMask[i] = |syndromes[SYN_W*i +: SYN_W];
    end
  end

  // Saturating statistics: the corrected-block sum is one bit wider so overflow is visible.
  always_comb begin
    frameCnt_d = (frameCnt_q == '1) ? frameCnt_q : frameCnt_q + CNT_W'(1);
    corrSum    = {1'b0, corrCnt_q} + (CNT_W+1)'(popcount8(errMask_q));
    corrCnt_d  = corrSum[CNT_W] ? '1 : corrSum[CNT_W-1:0];
  end

  // Main FSM: fill the frame, spend one cycle capturing the decode, then hold it until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      frame_q     <= '0;
      inReady_q   <= 1'b1;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      errMask_q   <= '0;
      syndromes_q <= '0;
      frameCnt_q  <= '0;
      corrCnt_q   <= '0;
    end else begin
      case (state_q)
        FILL: begin
          frame_q <= frame_d;
          if (accept) begin
            idx_q <= idx_q + 3'd1;
          end
          if (goDecode) begin
            state_q   <= DECODE;
            inReady_q <= 1'b0;
          end
        end
        DECODE: begin
          outData_q   <= decData;
          errMask_q   <= errMask;
          syndromes_q <= syndromes;
          outValid_q  <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            frameCnt_q <= frameCnt_d;
            corrCnt_q  <= corrCnt_d;
            frame_q    <= '0;
            idx_q      <= '0;
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= FILL;
          end
        end
        default: begin
          state_q    <= FILL;
          idx_q      <= '0;
          frame_q    <= '0;
          outValid_q <= 1'b0;
          inReady_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready      = inReady_q;
  assign out_valid     = outValid_q;
  assign out_data      = outData_q;
  assign out_err_mask  = errMask_q;
  assign out_syndromes = syndromes_q;
  assign frame_count   = frameCnt_q;
  assign corr_count    = corrCnt_q;

endmodule

// File: tb/tb_hamming_frame_sequencer.sv
// Self-checking bench for hamming_frame_sequencer: directed scenarios plus randomized frames,
// compared against a position-XOR Hamming model and a frame-level scoreboard.
module tb_hamming_frame_sequencer;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [15:0]         in_word;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [63:0]         out_data;
  logic [7:0]          out_err_mask;
  logic [31:0]         out_syndromes;
  logic [TB_CNT_W-1:0] frame_count;
  logic [TB_CNT_W-1:0] corr_count;

  int total = 0;
  int bad   = 0;

  logic [15:0] pend[$];
  logic [63:0] expData;
  logic [7:0]  expMask;
  logic [31:0] expSyn;
  int          modelFrames;
  int          modelCorr;
  int          dataBit [8] = '{12, 10, 9, 8, 6, 5, 4, 3};

  hamming_frame_sequencer #(.CNT_W(TB_CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_word       (in_word),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_err_mask  (out_err_mask),
    .out_syndromes (out_syndromes),
    .frame_count   (frame_count),
    .corr_count    (corr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  // XOR of the 1-based positions of every set bit (position p sits at bit 15-p).
  function automatic logic [3:0] posXor(input logic [15:0] cw);
    int p;
    p = 0;
    for (int b = 3; b <= 14; b++) begin
      if (cw[b]) p = p ^ (15 - b);
    end
    return 4'(p);
  endfunction

  function automatic logic [15:0] encodeByte(input logic [7:0] d);
    logic [15:0] cw;
    logic [3:0]  s;
    cw = '0;
    for (int k = 0; k < 8; k++) cw[dataBit[k]] = d[7-k];
    s = posXor(cw);
    cw[14] = s[0];
    cw[13] = s[1];
    cw[11] = s[2];
    cw[7]  = s[3];
    return cw;
  endfunction

  task automatic modelBlock(input logic [15:0] cw, output logic [7:0] b, output logic [3:0] s);
    logic [15:0] fixed;
    s = posXor(cw);
    fixed = cw;
    if (s inside {4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12}) begin
      fixed[15 - int'(s)] = ~fixed[15 - int'(s)];
    end
    for (int k = 0; k < 8; k++) b[7-k] = fixed[dataBit[k]];
  endtask

  task automatic finishFrame();
    logic [15:0] w;
    logic [7:0]  b;
    logic [3:0]  s;
    for (int i = 0; i < 8; i++) begin
      w = (i < pend.size()) ? pend[i] : 16'h0000;
      modelBlock(w, b, s);
      expData[8*i +: 8] = b;
      expSyn[4*i +: 4]  = s;
      expMask[i]        = |s;
    end
    pend.delete();
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] word, input logic valid, input logic doFlush);
    in_word  = word;
    in_valid = valid;
    flush    = doFlush;
    if (valid) checkOutput("inReadyFill", 64'(in_ready), 64'(1));
    stepCycle();
    in_valid = 1'b0;
    flush    = 1'b0;
    if (valid) pend.push_back(word);
    if (pend.size() == 8 || (doFlush && pend.size() > 0)) finishFrame();
  endtask

  task automatic doReset();
    rst = 1'b1;
    stepCycle();
    stepCycle();
    rst = 1'b0;
    pend.delete();
    modelFrames = 0;
    modelCorr   = 0;
  endtask

  task automatic checkResetState();
    checkOutput("rstOutValid", 64'(out_valid), 64'(0));
    checkOutput("rstInReady", 64'(in_ready), 64'(1));
    checkOutput("rstOutData", out_data, 64'(0));
    checkOutput("rstErrMask", 64'(out_err_mask), 64'(0));
    checkOutput("rstSyndromes", 64'(out_syndromes), 64'(0));
    checkOutput("rstFrameCount", 64'(frame_count), 64'(0));
    checkOutput("rstCorrCount", 64'(corr_count), 64'(0));
  endtask

  task automatic awaitFrame(input string tag, input int stall);
    int waited;
    int pc;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 20) begin
      stepCycle();
      waited++;
    end
    checkOutput({tag, ".outValid"}, 64'(out_valid), 64'(1));
    checkOutput({tag, ".data"}, out_data, expData);
    checkOutput({tag, ".mask"}, 64'(out_err_mask), 64'(expMask));
    checkOutput({tag, ".syn"}, 64'(out_syndromes), 64'(expSyn));
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom);
      in_word  = 16'($urandom);
      flush    = 1'($urandom);
      stepCycle();
      checkOutput({tag, ".stallValid"}, 64'(out_valid), 64'(1));
      checkOutput({tag, ".stallInReady"}, 64'(in_ready), 64'(0));
      checkOutput({tag, ".stallData"}, out_data, expData);
      checkOutput({tag, ".stallFrames"}, 64'(frame_count), 64'(modelFrames));
      checkOutput({tag, ".stallCorr"}, 64'(corr_count), 64'(modelCorr));
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    stepCycle();
    out_ready = 1'b0;
    pc = 0;
    for (int i = 0; i < 8; i++) pc += int'(expMask[i]);
    modelFrames = (modelFrames + 1 > CNT_MAX) ? CNT_MAX : modelFrames + 1;
    modelCorr   = (modelCorr + pc > CNT_MAX) ? CNT_MAX : modelCorr + pc;
    checkOutput({tag, ".frameCount"}, 64'(frame_count), 64'(modelFrames));
    checkOutput({tag, ".corrCount"}, 64'(corr_count), 64'(modelCorr));
    checkOutput({tag, ".validDrop"}, 64'(out_valid), 64'(0));
    checkOutput({tag, ".readyBack"}, 64'(in_ready), 64'(1));
  endtask

  function automatic logic [15:0] genWord();
    logic [15:0] cw;
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 16'($urandom);
    cw = encodeByte(8'($urandom));
    if (r >= 5) cw[$urandom_range(0, 15)] ^= 1'b1;
    return cw;
  endfunction

  initial begin
    logic [15:0] w;
    int n;
    int mode;
    rst = 1'b1; in_valid = 1'b0; in_word = '0; flush = 1'b0; out_ready = 1'b0;
    expData = '0; expMask = '0; expSyn = '0;
    modelFrames = 0; modelCorr = 0;

    doReset();
    checkResetState();

    // Flush with an empty frame is ignored.
    applyStimulus(16'h0000, 1'b0, 1'b1);
    stepCycle();
    checkOutput("emptyFlushValid", 64'(out_valid), 64'(0));
    checkOutput("emptyFlushReady", 64'(in_ready), 64'(1));

    // Clean frame, with exact latency from the last accept.
    for (int i = 0; i < 8; i++) applyStimulus(16'h7778, 1'b1, 1'b0);
    checkOutput("decodeCycleValid", 64'(out_valid), 64'(0));
    checkOutput("decodeCycleReady", 64'(in_ready), 64'(0));
    stepCycle();
    checkOutput("latencyValid", 64'(out_valid), 64'(1));
    checkOutput("cleanData", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
    awaitFrame("clean", 0);

    // Block 3 has data bit 12 flipped.
    for (int i = 0; i < 8; i++) applyStimulus((i == 3) ? 16'h6778 : 16'h7778, 1'b1, 1'b0);
    awaitFrame("block3", 0);
    checkOutput("block3CorrFixed", 64'(corr_count), 64'(1));

    // Three words, then a flush on its own cycle.
    for (int i = 0; i < 3; i++) applyStimulus(16'h7778, 1'b1, 1'b0);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("flushExpect", expData, 64'h0000_0000_00FF_FFFF);
    awaitFrame("flushSep", 0);

    // Flush coinciding with the third accept.
    applyStimulus(encodeByte(8'hA5), 1'b1, 1'b0);
    applyStimulus(encodeByte(8'h3C), 1'b1, 1'b0);
    applyStimulus(encodeByte(8'h81), 1'b1, 1'b1);
    awaitFrame("flushSame", 0);

    // Consumer stalls for 20 cycles while the input side is hammered.
    for (int i = 0; i < 8; i++) applyStimulus(genWord(), 1'b1, 1'b0);
    awaitFrame("stall20", 20);

    // Reset in the middle of a frame discards the partial words.
    for (int i = 0; i < 5; i++) applyStimulus(16'h7778, 1'b1, 1'b0);
    doReset();
    checkResetState();
    for (int i = 0; i < 8; i++) applyStimulus(16'h0000, 1'b1, 1'b0);
    awaitFrame("afterReset", 0);
    checkOutput("afterResetFrames", 64'(frame_count), 64'(1));

    // Randomized frames of random length with both flush styles and random stalls.
    for (int f = 0; f < 14; f++) begin
      n    = int'($urandom_range(1, 8));
      mode = int'($urandom_range(0, 2));
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) applyStimulus(16'h0000, 1'b0, 1'b0);
        applyStimulus(genWord(), 1'b1, (k == n - 1) && (n < 8) && (mode == 0));
      end
      if (n < 8 && mode != 0) applyStimulus(16'h0000, 1'b0, 1'b1);
      awaitFrame($sformatf("rand%0d", f), int'($urandom_range(0, 3)));
    end

    // Saturation: sixteen frames, each with two corrected blocks.
    doReset();
    checkResetState();
    for (int f = 0; f < 16; f++) begin
      for (int i = 0; i < 8; i++) begin
        w = encodeByte(8'($urandom));
        if (i == 1 || i == 6) w[dataBit[$urandom_range(0, 7)]] ^= 1'b1;
        applyStimulus(w, 1'b1, 1'b0);
      end
      awaitFrame($sformatf("sat%0d", f), 0);
    end
    checkOutput("satFrameCount", 64'(frame_count), 64'(15));
    checkOutput("satCorrCount", 64'(corr_count), 64'(15));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_frame_sequencer.md
Name: hamming_frame_sequencer

Overview:
Streaming front-end for the combinational 8-block Hamming decoder. Collects eight 16-bit codewords over a valid/ready input into one 128-bit frame and drives the decoder with it. Registers the 64-bit decoded result, a per-block error mask and per-block syndromes, and presents them on a valid/ready output. Keeps saturating statistics counters for frames and corrected blocks.

Parameters:
CNT_W, 16, width of the frame and corrected-block statistics counters (saturating).

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  codeword valid
in_ready  output  1  sequencer accepts a codeword this cycle
in_word  input  16  Hamming codeword; data bits at 12,10,9,8,6,5,4,3; parity bits at 14,13,11,7; bit 15 ignored
flush  input  1  pad the current partial frame with zero codewords and decode it
out_valid  output  1  decoded frame available
out_ready  input  1  consumer takes the frame
out_data  output  64  decoded bytes; byte i = block i (word i of the frame)
out_err_mask  output  8  bit i set = block i had a nonzero syndrome
out_syndromes  output  32  block i syndrome at bits [4i+3:4i], ordered {p3,p2,p1,p0}
frame_count  output  CNT_W  frames delivered, saturating
corr_count  output  CNT_W  blocks with nonzero syndrome delivered, saturating

Behaviour:
- Reset: state FILL, word index 0, frame register 0, out_valid 0, out_data/out_err_mask/out_syndromes 0, both counters 0. Reset mid-frame discards the partial frame and any undelivered output.
- States:
  - FILL: in_ready=1. Each in_valid&in_ready handshake writes in_word to frame bits [16*idx +: 16] and increments idx. On the eighth accept (idx==7), go to DECODE.
  - DECODE: one cycle, in_ready=0. Register the decoder output, the 8 syndromes and the error mask. Go to OUT.
  - OUT: out_valid=1, in_ready=0. Outputs stay stable until out_ready. On out_valid&out_ready: increment frame_count; add popcount(err_mask) to corr_count, saturating at all-ones; clear frame and idx; go to FILL.
- Latency: last codeword accepted at cycle t gives out_valid high at t+2. Best-case throughput is one frame per 10 cycles with out_ready held high.
- Flush:
  - In FILL with idx>0: words idx..7 are zeroed (zero decodes to 0x00 with syndrome 0), then go to DECODE.
  - Same cycle as an accept: the word is taken first, then the remainder is padded.
  - With idx==0 and no accept: ignored.
  - Outside FILL: ignored.
- Syndrome per block, computed in the sequencer:
  - p0 = b14^b12^b10^b8^b6^b4
  - p1 = b13^b12^b9^b8^b5^b4
  - p2 = b11^b10^b9^b8^b3
  - p3 = b7^b6^b5^b4^b3
  - Mask bit = |syndrome. A syndrome that points at a parity bit or an unused position still sets the mask bit; the data byte is unmodified in that case.
- Decoded data always comes from the decoder's data_out. The decoder's error_positions port is left unconnected.
- No combinational path from in_valid or out_ready to any output.

Decomposition:
- Package hamming_pkg:
  - constants BLOCKS=8, CW_W=16, BYTE_W=8, SYN_W=4
  - state enum {FILL, DECODE, OUT}
  - function syndrome(cw) returning 4 bits
  - function popcount8
- One sub-module: instance of the existing combinational decoder module, fed from the frame register.

Test Plan:
- Eight words of 16'h7778 with out_ready=1 -> out_data=64'hFFFF_FFFF_FFFF_FFFF, out_err_mask=0, out_syndromes=0, out_valid 2 cycles after the last accept, frame_count=1.
- Block 3 = 16'h6778 (bit 12 flipped), others 16'h7778 -> out_data all 0xFF, out_err_mask=8'h08, out_syndromes[15:12]=4'b0011, corr_count=1.
- Three words of 16'h7778, then flush -> out_data=64'h0000_0000_00FF_FFFF, out_err_mask=0.
- out_ready held low for 20 cycles in OUT -> out_data stable, in_ready=0, incoming in_valid ignored, counters unchanged until the handshake.
- rst asserted after 5 accepted words, then eight fresh 16'h0000 words -> out_data=0, frame_count=1; no stale words appear.
- CNT_W=4, 16 frames each with two flagged blocks -> corr_count saturates at 15, frame_count saturates at 15.
